// File: rtl/nexys_starship_pkg.sv
// nexys_starship_pkg
// Shared definitions for the Starship fault generator:
//   - state_t    : scheduler state encoding (IDLE, ARMED, FIRE)
//   - RIGHT/LEFT/UP/DOWN : station index constants, matching bit
//                  positions of station_broken and break_req
//   - LFSR_TAPS  : Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
//   - lfsr_next  : one right-shifting Galois LFSR step
package nexys_starship_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } state_t;

  localparam logic [1:0] RIGHT = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] UP    = 2'd2;
  localparam logic [1:0] DOWN  = 2'd3;

  // Taps 16,14,13,11 map to bits 15,13,12,10 in a right-shifting Galois LFSR
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// nexys_starship_lfsr16
// Free-running 16-bit Galois LFSR that advances every clock cycle.
// Ports:
//   clock : clock
//   reset : synchronous active-low reset, loads SEED
//   state : current 16-bit LFSR state
// SEED must be nonzero; a maximal-length LFSR started from a nonzero value
// never reaches the all-zero lock-up state.
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= SEED;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/nexys_starship_fault_gen.sv
// nexys_starship_fault_gen
// Fault scheduler for the Starship game. After play_flag it counts down an
// interval that shrinks after every expiry, and at each expiry emits a
// one-cycle break request to a pseudo-randomly chosen, not-yet-broken
// station together with a 4-bit repair combo.
// Ports:
//   Clk            : clock
//   Reset          : synchronous active-low reset
//   play_flag      : start a game (honoured only in IDLE)
//   gameover_ctrl  : abort the running game
//   station_broken : per-station broken flags {DOWN, UP, LEFT, RIGHT}
//   break_req      : registered one-hot fault pulse, bit0 drives RR_random
//   random_hex     : repair combo of the most recent fault (never 4'h0)
//   fault_count    : faults issued this game, saturating at 8'hFF
//   active         : high while in ARMED or FIRE
module nexys_starship_fault_gen
  import nexys_starship_pkg::*;
#(
  parameter logic [27:0] INTERVAL_INIT = 28'd200_000_000,
  parameter logic [27:0] INTERVAL_STEP = 28'd10_000_000,
  parameter logic [27:0] INTERVAL_MIN  = 28'd50_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [3:0] station_broken,
  output logic [3:0] break_req,
  output logic [3:0] random_hex,
  output logic [7:0] fault_count,
  output logic       active
);

  state_t      state;
  logic [27:0] interval;
  logic [27:0] countdown;
  logic [27:0] next_interval;
  logic [15:0] lfsr;
  logic [1:0]  sel;
  logic        sel_found;
  logic [3:0]  sel_onehot;
  logic [3:0]  hex_next;
  logic        lfsr_unused;

  nexys_starship_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock (Clk),
    .reset (Reset),
    .state (lfsr)
  );

  // Only lfsr[1:0] and lfsr[7:4] feed the selection and the combo
  assign lfsr_unused = ^{lfsr[15:8], lfsr[3:2]};

  // Start at lfsr[1:0] and walk forward (mod 4) to the first healthy station
  always_comb begin
    logic [1:0] cand;
    sel       = lfsr[1:0];
    sel_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = lfsr[1:0] + 2'(i);
      if (!sel_found && !station_broken[cand]) begin
        sel_found = 1'b1;
        sel       = cand;
      end
    end
  end

  always_comb begin
    sel_onehot = 4'b0000;
    case (sel)
      RIGHT:   sel_onehot = 4'b0001;
      LEFT:    sel_onehot = 4'b0010;
      UP:      sel_onehot = 4'b0100;
      DOWN:    sel_onehot = 4'b1000;
      default: sel_onehot = 4'b0000;
    endcase
  end

  // A zero combo would be indistinguishable from "no combo" on the display
  assign hex_next = (lfsr[7:4] == 4'h0) ? 4'hF : lfsr[7:4];

  // Ramp toward the floor; the difference test avoids unsigned underflow
  always_comb begin
    if ((interval >= INTERVAL_MIN) && ((interval - INTERVAL_MIN) >= INTERVAL_STEP)) begin
      next_interval = interval - INTERVAL_STEP;
    end else begin
      next_interval = INTERVAL_MIN;
    end
  end

  // Scheduler FSM. The fault decision is taken on the edge that enters FIRE
  // so the registered break_req is high exactly during the FIRE cycle.
  // gameover_ctrl is tested first in ARMED so it wins over expiry.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= IDLE;
      break_req   <= 4'b0000;
      random_hex  <= 4'h0;
      fault_count <= 8'h00;
      active      <= 1'b0;
      interval    <= INTERVAL_INIT;
      countdown   <= 28'd0;
    end else begin
      break_req <= 4'b0000;
      case (state)
        IDLE: begin
          if (play_flag && !gameover_ctrl) begin
            state       <= ARMED;
            active      <= 1'b1;
            interval    <= INTERVAL_INIT;
            countdown   <= INTERVAL_INIT - 28'd1;
            fault_count <= 8'h00;
          end
        end
        ARMED: begin
          if (gameover_ctrl) begin
            state  <= IDLE;
            active <= 1'b0;
          end else if (countdown == 28'd0) begin
            state <= FIRE;
            if (sel_found) begin
              break_req  <= sel_onehot;
              random_hex <= hex_next;
              if (fault_count != 8'hFF) begin
                fault_count <= fault_count + 8'd1;
              end
            end
          end else begin
            countdown <= countdown - 28'd1;
          end
        end
        FIRE: begin
          if (gameover_ctrl) begin
            state  <= IDLE;
            active <= 1'b0;
          end else begin
            state     <= ARMED;
            interval  <= next_interval;
            countdown <= next_interval - 28'd1;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nexys_starship_fault_gen.sv
// tb_nexys_starship_fault_gen
// Directed bench for nexys_starship_fault_gen with INTERVAL_INIT=10,
// INTERVAL_STEP=2, INTERVAL_MIN=4. A reference LFSR runs in lockstep with
// the DUT so the station choice and combo of each pulse can be predicted.
module tb_nexys_starship_fault_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clock;
  logic       resetN;
  logic       playFlag;
  logic       gameoverCtrl;
  logic [3:0] stationBroken;
  logic [3:0] breakReq;
  logic [3:0] randomHex;
  logic [7:0] faultCount;
  logic       active;

  logic [15:0] modelLfsr;
  int          vectorCount;
  int          missCount;

  nexys_starship_fault_gen #(
    .INTERVAL_INIT (28'd10),
    .INTERVAL_STEP (28'd2),
    .INTERVAL_MIN  (28'd4),
    .LFSR_SEED     (SEED)
  ) dut (
    .Clk            (clock),
    .Reset          (resetN),
    .play_flag      (playFlag),
    .gameover_ctrl  (gameoverCtrl),
    .station_broken (stationBroken),
    .break_req      (breakReq),
    .random_hex     (randomHex),
    .fault_count    (faultCount),
    .active         (active)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference Galois step written as explicit bit flips on bits 15,13,12,10
  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) begin
      r[15] = ~r[15];
      r[13] = ~r[13];
      r[12] = ~r[12];
      r[10] = ~r[10];
    end
    return r;
  endfunction

  // Reference LFSR follows the DUT reset and advances on every rising edge
  always @(posedge clock) begin
    if (!resetN) modelLfsr <= SEED;
    else         modelLfsr <= lfsrStep(modelLfsr);
  end

  function automatic logic [3:0] expectedReq(input logic [15:0] l, input logic [3:0] broken);
    int st;
    for (int off = 0; off < 4; off++) begin
      st = (int'(l[1:0]) + off) % 4;
      if (broken[st] == 1'b0) return 4'(1 << st);
    end
    return 4'b0000;
  endfunction

  function automatic logic [3:0] expectedHex(input logic [15:0] l);
    return (l[7:4] == 4'h0) ? 4'hF : l[7:4];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive all inputs, then advance the given number of falling edges
  task automatic applyStimulus(input logic rst, input logic play, input logic over,
                               input logic [3:0] broken, input int cycles);
    resetN        = rst;
    playFlag      = play;
    gameoverCtrl  = over;
    stationBroken = broken;
    repeat (cycles) @(negedge clock);
  endtask

  // Step until break_req pulses or the budget runs out; reports the number of
  // cycles advanced and the reference LFSR value of the expiry cycle
  task automatic waitPulse(input int budget, output int gap, output bit found,
                           output logic [15:0] expiryLfsr);
    int n;
    logic [15:0] prev;
    n = 0;
    found = 1'b0;
    gap = 0;
    expiryLfsr = 16'h0000;
    while (!found && n < budget) begin
      prev = modelLfsr;
      @(negedge clock);
      n++;
      if (breakReq != 4'b0000) begin
        found = 1'b1;
        gap = n;
        expiryLfsr = prev;
      end
    end
  endtask

  task automatic checkPulse(input string tag, input bit found, input int gap, input int expGap,
                            input logic [15:0] expiryLfsr, input logic [7:0] expCount);
    checkOutput({tag, "_seen"}, 32'(found), 32'd1);
    checkOutput({tag, "_gap"}, 32'(gap), 32'(expGap));
    checkOutput({tag, "_req"}, 32'(breakReq), 32'(expectedReq(expiryLfsr, stationBroken)));
    checkOutput({tag, "_hex"}, 32'(randomHex), 32'(expectedHex(expiryLfsr)));
    checkOutput({tag, "_count"}, 32'(faultCount), 32'(expCount));
  endtask

  initial begin
    int          gap;
    bit          found;
    logic [15:0] expL;
    logic [15:0] probe;
    logic [3:0]  lastHex;
    bit          hit;
    int          gapList [5] = '{9, 7, 5, 5, 5};

    vectorCount = 0;
    missCount   = 0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 2);
    checkOutput("rst_req", 32'(breakReq), 32'd0);
    checkOutput("rst_hex", 32'(randomHex), 32'd0);
    checkOutput("rst_count", 32'(faultCount), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);

    // Start a game: first pulse 10 cycles after ARMED entry
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1);
    checkOutput("start_active", 32'(active), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 0);
    waitPulse(30, gap, found, expL);
    checkPulse("first", found, gap, 10, expL, 8'd1);

    // Free run: interval ramps 8, 6, 4 then holds at the floor
    for (int k = 0; k < 5; k++) begin
      waitPulse(30, gap, found, expL);
      checkPulse($sformatf("ramp%0d", k), found, gap, gapList[k], expL, 8'(k + 2));
    end
    lastHex = expectedHex(expL);

    // Combo holds between pulses; gameover on the expiry cycle suppresses the pulse
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 4);
    checkOutput("hold_req", 32'(breakReq), 32'd0);
    checkOutput("hold_hex", 32'(randomHex), 32'(lastHex));
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000, 1);
    checkOutput("over_req", 32'(breakReq), 32'd0);
    checkOutput("over_active", 32'(active), 32'd0);
    checkOutput("over_count", 32'(faultCount), 32'd6);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b0000, 1);
    checkOutput("play_and_over", 32'(active), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 0);
    waitPulse(15, gap, found, expL);
    checkOutput("idle_no_pulse", 32'(found), 32'd0);

    // All stations broken: expiries at 10,19,26,31,36 stay silent, ramp continues
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b1111, 1);
    checkOutput("allbrk_active", 32'(active), 32'd1);
    checkOutput("allbrk_clear", 32'(faultCount), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b1111, 0);
    waitPulse(40, gap, found, expL);
    checkOutput("allbrk_no_pulse", 32'(found), 32'd0);
    checkOutput("allbrk_count", 32'(faultCount), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 0);
    waitPulse(3, gap, found, expL);
    checkPulse("allbrk_floor", found, gap, 1, expL, 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000, 1);
    checkOutput("end_active", 32'(active), 32'd0);

    // Time the start so the expiry sees lfsr[1:0]=0 and lfsr[7:4]=0
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001, 0);
    hit = 1'b0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      probe = modelLfsr;
      repeat (10) probe = lfsrStep(probe);
      if (probe[1:0] == 2'd0 && probe[7:4] == 4'h0) hit = 1'b1;
      else @(negedge clock);
    end
    checkOutput("force_search", 32'(hit), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0001, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001, 0);
    waitPulse(20, gap, found, expL);
    checkPulse("force", found, gap, 10, expL, 8'd1);
    checkOutput("force_req", 32'(breakReq), 32'h2);
    checkOutput("force_hex", 32'(randomHex), 32'hF);

    // Reset mid-ARMED clears everything; a new game restarts at interval 10
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);
    checkOutput("midrst_req", 32'(breakReq), 32'd0);
    checkOutput("midrst_hex", 32'(randomHex), 32'd0);
    checkOutput("midrst_count", 32'(faultCount), 32'd0);
    checkOutput("midrst_active", 32'(active), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1);
    checkOutput("restart_active", 32'(active), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 0);
    waitPulse(20, gap, found, expL);
    checkPulse("restart", found, gap, 10, expL, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
